// File: rtl/conv_addr_seq.sv
// Convolution address sequencer: walks output pixels in row-major order and, for each,
// streams channel/filter-row address pairs to the PE array using only adders per beat.
module conv_addr_seq #(
  parameter int Ma  = 16,
  parameter int S_f = 5,
  parameter int N_f = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [Ma-1:0] S_in,
  input  logic [Ma-1:0] N_ch,
  input  logic [1:0]    stride,
  input  logic          ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          v_out,
  output logic [Ma-1:0] Ai,
  output logic [Ma-1:0] Aw,
  output logic [Ma-1:0] Awf,
  output logic          acc_first,
  output logic          acc_last,
  output logic [Ma-1:0] Ao,
  output logic [Ma-1:0] o_row,
  output logic [Ma-1:0] o_col
);

  if (S_f < 1 || N_f < 1) begin : g_param_check
    $error("conv_addr_seq: S_f and N_f must be at least 1");
  end

  localparam logic [Ma-1:0] SF      = Ma'(S_f);
  localparam logic [Ma-1:0] SF_LAST = Ma'(S_f - 1);
  localparam logic [Ma-1:0] SF_SQ   = Ma'(S_f * S_f);
  localparam logic [Ma-1:0] ONE     = Ma'(1);
  localparam logic [Ma-1:0] THREE   = Ma'(3);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t state, state_next;

  logic          cfg_bad;
  logic [Ma-1:0] stride_ext;
  logic [Ma-1:0] diff;
  logic [Ma-1:0] sco_last_calc;

  logic [Ma-1:0] s_in_q, n_ch_q, stride_q;
  logic [Ma-1:0] plane_q, row_step_q, awf_q, sco_last_q;
  logic [Ma-1:0] r_q, c_q, col_q, row_q;
  logic [Ma-1:0] ai_q, ch_base_q, pix_base_q, row_base_q, aw_q, ao_q;

  logic r_end, c_end, col_end, row_end, last_beat, accept;

  // Config check and last output index (S_C_o-1); the divide only feeds the latch.
  always_comb begin
    stride_ext    = {{(Ma-2){1'b0}}, stride};
    diff          = S_in - SF;
    cfg_bad       = (S_in < SF) || (N_ch == '0) || (stride == 2'd0);
    sco_last_calc = '0;
    case (stride)
      2'd1:    sco_last_calc = diff;
      2'd2:    sco_last_calc = diff >> 1;
      2'd3:    sco_last_calc = diff / THREE;
      default: sco_last_calc = '0;
    endcase
  end

  always_comb begin
    r_end     = (r_q == SF_LAST);
    c_end     = (c_q == n_ch_q - ONE);
    col_end   = (col_q == sco_last_q);
    row_end   = (row_q == sco_last_q);
    last_beat = r_end && c_end && col_end && row_end;
    accept    = (state == RUN) && ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Data outputs are gated by RUN so every output reads 0 outside a run.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    v_out      = 1'b0;
    Ai         = '0;
    Aw         = '0;
    Awf        = '0;
    acc_first  = 1'b0;
    acc_last   = 1'b0;
    Ao         = '0;
    o_row      = '0;
    o_col      = '0;
    case (state)
      IDLE: begin
        if (start) state_next = cfg_bad ? ERR : RUN;
      end
      RUN: begin
        busy      = 1'b1;
        v_out     = 1'b1;
        Ai        = ai_q;
        Aw        = aw_q;
        Awf       = awf_q;
        acc_first = (c_q == '0) && (r_q == '0);
        acc_last  = c_end && r_end;
        Ao        = ao_q;
        o_row     = row_q;
        o_col     = col_q;
        if (ready && last_beat) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        err        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Base registers: pixel row, pixel, channel and beat addresses advance by precomputed steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_in_q     <= '0;
      n_ch_q     <= '0;
      stride_q   <= '0;
      plane_q    <= '0;
      row_step_q <= '0;
      awf_q      <= '0;
      sco_last_q <= '0;
      r_q        <= '0;
      c_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      ai_q       <= '0;
      ch_base_q  <= '0;
      pix_base_q <= '0;
      row_base_q <= '0;
      aw_q       <= '0;
      ao_q       <= '0;
    end else if (state == IDLE && start && !cfg_bad) begin
      s_in_q     <= S_in;
      n_ch_q     <= N_ch;
      stride_q   <= stride_ext;
      plane_q    <= S_in * S_in;
      row_step_q <= stride_ext * S_in;
      awf_q      <= SF_SQ * N_ch;
      sco_last_q <= sco_last_calc;
      r_q        <= '0;
      c_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      ai_q       <= '0;
      ch_base_q  <= '0;
      pix_base_q <= '0;
      row_base_q <= '0;
      aw_q       <= '0;
      ao_q       <= '0;
    end else if (accept) begin
      aw_q <= aw_q + SF;
      if (!r_end) begin
        r_q  <= r_q + ONE;
        ai_q <= ai_q + s_in_q;
      end else begin
        r_q <= '0;
        if (!c_end) begin
          c_q       <= c_q + ONE;
          ch_base_q <= ch_base_q + plane_q;
          ai_q      <= ch_base_q + plane_q;
        end else begin
          c_q  <= '0;
          aw_q <= '0;
          ao_q <= ao_q + ONE;
          if (!col_end) begin
            col_q      <= col_q + ONE;
            pix_base_q <= pix_base_q + stride_q;
            ch_base_q  <= pix_base_q + stride_q;
            ai_q       <= pix_base_q + stride_q;
          end else begin
            col_q      <= '0;
            row_q      <= row_q + ONE;
            row_base_q <= row_base_q + row_step_q;
            pix_base_q <= row_base_q + row_step_q;
            ch_base_q  <= row_base_q + row_step_q;
            ai_q       <= row_base_q + row_step_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_addr_seq.sv
// Self-checking bench for conv_addr_seq: directed and randomized runs compared every cycle
// against an index-decomposition model of the output stream.
module tb_conv_addr_seq;

  localparam int MA = 16;
  localparam int SF = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [MA-1:0] s_in = '0;
  logic [MA-1:0] n_ch = '0;
  logic [1:0]    stride = '0;
  logic          ready = 1'b0;
  logic          busy, done, err, v_out, acc_first, acc_last;
  logic [MA-1:0] ai, aw, awf, ao, o_row, o_col;

  conv_addr_seq #(.Ma(MA), .S_f(SF), .N_f(6)) dut (
    .clk(clk), .rst(rst), .start(start), .S_in(s_in), .N_ch(n_ch), .stride(stride),
    .ready(ready), .busy(busy), .done(done), .err(err), .v_out(v_out),
    .Ai(ai), .Aw(aw), .Awf(awf), .acc_first(acc_first), .acc_last(acc_last),
    .Ao(ao), .o_row(o_row), .o_col(o_col)
  );

  always #5 clk = ~clk;

  typedef enum int {M_OFF, M_IDLE, M_RUN, M_DONE, M_ERR} mode_t;

  typedef struct {
    logic [MA-1:0] ai, aw, awf, ao, orow, ocol;
    logic          first, last;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  mode_t mode = M_OFF;
  int    exp_k = 0;
  int    m_sin = 0, m_nch = 0, m_str = 0;
  int    run_id = 0;

  // Reference: decompose the beat index into (o_row, o_col, c, r) and apply the address formulas.
  function automatic beat_t model_beat(int sin, int nch, int str, int k);
    beat_t b;
    int sco, r, c, oc, orw, t;
    sco = (sin - SF) / str + 1;
    r   = k % SF;
    t   = k / SF;
    c   = t % nch;
    t   = t / nch;
    oc  = t % sco;
    orw = t / sco;
    b.ai    = 16'(c * sin * sin + (orw * str + r) * sin + oc * str);
    b.aw    = 16'((c * SF + r) * SF);
    b.awf   = 16'(SF * SF * nch);
    b.ao    = 16'(orw * sco + oc);
    b.orow  = 16'(orw);
    b.ocol  = 16'(oc);
    b.first = (c == 0) && (r == 0);
    b.last  = (c == nch - 1) && (r == SF - 1);
    return b;
  endfunction

  function automatic int total_beats(int sin, int nch, int str);
    int sco;
    sco = (sin - SF) / str + 1;
    return sco * sco * nch * SF;
  endfunction

  task automatic check_output(input string name, input logic [MA-1:0] act, input logic [MA-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", name, act, exp, exp_k, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b (k=%0d, t=%0t)", name, act, exp, exp_k, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_vout"}, v_out, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
    check_bit({tag, "_err"}, err, 1'b0);
    check_bit({tag, "_first"}, acc_first, 1'b0);
    check_bit({tag, "_last"}, acc_last, 1'b0);
    check_output({tag, "_ai"}, ai, '0);
    check_output({tag, "_aw"}, aw, '0);
    check_output({tag, "_awf"}, awf, '0);
    check_output({tag, "_ao"}, ao, '0);
    check_output({tag, "_orow"}, o_row, '0);
    check_output({tag, "_ocol"}, o_col, '0);
  endtask

  // Single compare process: every cycle, outputs against the model for the current mode.
  always @(negedge clk) begin
    beat_t e;
    case (mode)
      M_RUN: begin
        e = model_beat(m_sin, m_nch, m_str, exp_k);
        check_bit("v_out", v_out, 1'b1);
        check_bit("busy", busy, 1'b1);
        check_bit("done_in_run", done, 1'b0);
        check_bit("err_in_run", err, 1'b0);
        check_output("Ai", ai, e.ai);
        check_output("Aw", aw, e.aw);
        check_output("Awf", awf, e.awf);
        check_output("Ao", ao, e.ao);
        check_output("o_row", o_row, e.orow);
        check_output("o_col", o_col, e.ocol);
        check_bit("acc_first", acc_first, e.first);
        check_bit("acc_last", acc_last, e.last);
        if (run_id == 1) begin
          case (exp_k)
            0: begin check_output("lit1_b0_ai", ai, 16'd0); check_bit("lit1_b0_first", acc_first, 1'b1); end
            4: begin
              check_output("lit1_b4_ai", ai, 16'd28); check_output("lit1_b4_aw", aw, 16'd20);
              check_bit("lit1_b4_last", acc_last, 1'b1); check_output("lit1_b4_ao", ao, 16'd0);
            end
            5: begin
              check_output("lit1_b5_ai", ai, 16'd1); check_output("lit1_b5_ocol", o_col, 16'd1);
              check_bit("lit1_b5_first", acc_first, 1'b1);
            end
            default: ;
          endcase
        end else if (run_id == 2) begin
          case (exp_k)
            5:  check_output("lit2_p01_ai", ai, 16'd2);
            15: check_output("lit2_p10_ai", ai, 16'd18);
            19: check_output("lit2_p10r4_ai", ai, 16'd54);
            44: begin check_output("lit2_p22_ai", ai, 16'd76); check_output("lit2_p22_ao", ao, 16'd8); end
            default: ;
          endcase
        end else if (run_id == 3) begin
          check_output("lit3_awf", awf, 16'd50);
          case (exp_k)
            2: begin check_output("lit3_b2_ai", ai, 16'd10); check_output("lit3_b2_aw", aw, 16'd10); end
            5: begin
              check_output("lit3_b5_ai", ai, 16'd25); check_output("lit3_b5_aw", aw, 16'd25);
              check_bit("lit3_b5_first", acc_first, 1'b0);
            end
            9: begin
              check_output("lit3_b9_ai", ai, 16'd45); check_output("lit3_b9_aw", aw, 16'd45);
              check_bit("lit3_b9_last", acc_last, 1'b1);
            end
            default: ;
          endcase
        end
      end
      M_DONE: begin
        check_bit("done_pulse", done, 1'b1);
        check_bit("done_busy", busy, 1'b0);
        check_bit("done_vout", v_out, 1'b0);
        check_bit("done_err", err, 1'b0);
      end
      M_ERR: begin
        check_bit("err_pulse", err, 1'b1);
        check_bit("err_busy", busy, 1'b0);
        check_bit("err_vout", v_out, 1'b0);
        check_bit("err_done", done, 1'b0);
      end
      M_IDLE: begin
        check_bit("idle_busy", busy, 1'b0);
        check_bit("idle_vout", v_out, 1'b0);
        check_bit("idle_done", done, 1'b0);
        check_bit("idle_err", err, 1'b0);
      end
      default: ;
    endcase
  end

  // One run: start, stream beats with the chosen ready pattern, then expect done and idle.
  task automatic apply_stimulus(input int sin, input int nch, input int str, input int id,
                                input bit rnd, input bit bp, input int abort_at);
    int total, hold, cycles, budget;
    total  = total_beats(sin, nch, str);
    budget = total * 6 + 20;
    hold   = 0;
    cycles = 0;
    @(posedge clk);
    #1;
    s_in   = 16'(sin);
    n_ch   = 16'(nch);
    stride = 2'(str);
    start  = 1'b1;
    ready  = 1'b1;
    if (bp && hold < 3 && 0 == 2) ready = 1'b0;
    else if (rnd) ready = ($urandom_range(0, 3) != 0);
    @(posedge clk);
    m_sin  = sin;
    m_nch  = nch;
    m_str  = str;
    run_id = id;
    exp_k  = 0;
    mode   = M_RUN;
    #1 start = 1'b0;
    while (1) begin
      @(posedge clk);
      if (ready) exp_k++;
      cycles++;
      if (exp_k == total) break;
      if (abort_at >= 0 && exp_k == abort_at) begin
        mode = M_OFF;
        #3 rst = 1'b0;
        #1 check_all_zero("abort");
        @(posedge clk);
        #1 rst = 1'b1;
        ready = 1'b0;
        mode  = M_IDLE;
        return;
      end
      if (cycles > budget) begin
        errors++;
        $display("[TB] FAIL run_timeout: got %0d beats expected %0d", exp_k, total);
        mode = M_OFF;
        #1 rst = 1'b0;
        #4 rst = 1'b1;
        mode = M_IDLE;
        return;
      end
      #1;
      if (bp && exp_k == 2 && hold < 3) begin
        ready = 1'b0;
        hold++;
      end else if (rnd) begin
        ready = ($urandom_range(0, 3) != 0);
      end else begin
        ready = 1'b1;
      end
      if (rnd) begin
        start  = ($urandom_range(0, 7) == 0);
        s_in   = 16'($urandom_range(0, 40));
        n_ch   = 16'($urandom_range(0, 5));
        stride = 2'($urandom_range(0, 3));
      end
    end
    mode = M_DONE;
    #1;
    start = 1'b0;
    ready = 1'b0;
    @(posedge clk);
    mode = M_IDLE;
    @(posedge clk);
  endtask

  task automatic apply_bad_config(input int sin, input int nch, input int str);
    @(posedge clk);
    #1;
    s_in   = 16'(sin);
    n_ch   = 16'(nch);
    stride = 2'(str);
    start  = 1'b1;
    mode   = M_IDLE;
    @(posedge clk);
    mode = M_ERR;
    #1 start = 1'b0;
    @(posedge clk);
    mode = M_IDLE;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    #12 check_all_zero("reset");
    #10 rst = 1'b1;
    mode = M_IDLE;

    apply_stimulus(7, 1, 1, 1, 1'b0, 1'b1, -1);
    apply_stimulus(9, 1, 2, 2, 1'b0, 1'b0, -1);
    apply_stimulus(5, 2, 1, 3, 1'b0, 1'b1, -1);

    apply_bad_config(4, 1, 1);
    apply_bad_config(7, 0, 1);
    apply_bad_config(7, 1, 0);

    apply_stimulus(5, 1, 3, 0, 1'b1, 1'b0, -1);
    apply_stimulus(10, 2, 3, 0, 1'b1, 1'b0, -1);
    apply_stimulus(12, 1, 2, 0, 1'b1, 1'b0, -1);

    apply_stimulus(8, 2, 1, 0, 1'b1, 1'b0, 17);
    apply_stimulus(7, 1, 1, 1, 1'b1, 1'b0, -1);

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(SF + $urandom_range(0, 8), $urandom_range(1, 3), $urandom_range(1, 3),
                     0, 1'b1, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
